// File: rtl/axi_grid_mni.sv
// axi_grid_mni -- master-side network interface of the AXI grid.
//
// Grid AW/W/AR flits arriving at this node are replayed as AXI manager traffic
// onto a single local subordinate. B and R beats are wrapped back into grid
// flits addressed to the slave-side NI that issued the request. One write and
// one read may be outstanding at a time. The two paths are independent.
//
// Ports:
//   clk_i, arst_ni                     clock, asynchronous active-low reset
//   req_o / resp_i                     AXI manager request / subordinate response
//   grid_aw_i/_valid_i/_ready_o        incoming write-address flit
//   grid_w_i/_valid_i/_ready_o         incoming write-data flit
//   grid_ar_i/_valid_i/_ready_o        incoming read-address flit
//   grid_b_o/_valid_o/_ready_i         outgoing write-response flit
//   grid_r_o/_valid_o/_ready_i         outgoing read-data flit

package axi_default_param_pkg;
    typedef logic [3:0]  grid_id_t;
    typedef logic [3:0]  axi_id_t;
    typedef logic [31:0] axi_addr_t;
    typedef logic [31:0] axi_data_t;
    typedef logic [3:0]  axi_strb_t;

    typedef struct packed {
        axi_id_t     id;
        axi_addr_t   addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_chan_t;

    typedef struct packed {
        axi_data_t   data;
        axi_strb_t   strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        axi_id_t     id;
        logic [1:0]  resp;
    } b_chan_t;

    typedef struct packed {
        axi_id_t     id;
        axi_addr_t   addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_chan_t;

    typedef struct packed {
        axi_id_t     id;
        axi_data_t   data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t    aw;
        logic        aw_valid;
        w_chan_t     w;
        logic        w_valid;
        logic        b_ready;
        ar_chan_t    ar;
        logic        ar_valid;
        logic        r_ready;
    } mni_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        b_chan_t     b;
        logic        b_valid;
        logic        ar_ready;
        r_chan_t     r;
        logic        r_valid;
    } mni_resp_t;

    typedef struct packed { grid_id_t src; grid_id_t dst; aw_chan_t payload; } grid_aw_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; w_chan_t  payload; } grid_w_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; b_chan_t  payload; } grid_b_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; ar_chan_t payload; } grid_ar_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; r_chan_t  payload; } grid_r_chan_t;
endpackage

module axi_grid_mni #(
    parameter type req_t          = axi_default_param_pkg::mni_req_t,
    parameter type resp_t         = axi_default_param_pkg::mni_resp_t,
    parameter type grid_id_t      = axi_default_param_pkg::grid_id_t,
    parameter type grid_aw_chan_t = axi_default_param_pkg::grid_aw_chan_t,
    parameter type grid_w_chan_t  = axi_default_param_pkg::grid_w_chan_t,
    parameter type grid_b_chan_t  = axi_default_param_pkg::grid_b_chan_t,
    parameter type grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
    parameter type grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
    parameter grid_id_t NI_ID     = '0
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    output req_t          req_o,
    input  resp_t         resp_i,
    input  grid_aw_chan_t grid_aw_i,
    input  logic          grid_aw_valid_i,
    output logic          grid_aw_ready_o,
    input  grid_w_chan_t  grid_w_i,
    input  logic          grid_w_valid_i,
    output logic          grid_w_ready_o,
    input  grid_ar_chan_t grid_ar_i,
    input  logic          grid_ar_valid_i,
    output logic          grid_ar_ready_o,
    output grid_b_chan_t  grid_b_o,
    output logic          grid_b_valid_o,
    input  logic          grid_b_ready_i,
    output grid_r_chan_t  grid_r_o,
    output logic          grid_r_valid_o,
    input  logic          grid_r_ready_i
);

    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA}         r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    axi_default_param_pkg::aw_chan_t aw_q, aw_d;
    axi_default_param_pkg::ar_chan_t ar_q, ar_d;
    grid_id_t wr_src_q, wr_src_d;
    grid_id_t rd_src_q, rd_src_d;

    logic aw_hs, aw_acc, w_last_hs, b_hs;
    logic ar_hs, ar_acc, r_last_hs;

    // Handshakes are formed from this block's own outputs, which already
    // encode the current state, so each one can only fire in its own state.
    assign aw_hs     = grid_aw_valid_i & grid_aw_ready_o;
    assign aw_acc    = req_o.aw_valid & resp_i.aw_ready;
    assign w_last_hs = req_o.w_valid & resp_i.w_ready & req_o.w.last;
    assign b_hs      = grid_b_valid_o & grid_b_ready_i;
    assign ar_hs     = grid_ar_valid_i & grid_ar_ready_o;
    assign ar_acc    = req_o.ar_valid & resp_i.ar_ready;
    assign r_last_hs = grid_r_valid_o & grid_r_ready_i & resp_i.r.last;

    // The routing check below is the only consumer of the dst fields.
    logic unused_dst;
    assign unused_dst = ^{grid_aw_i.dst, grid_w_i.src, grid_w_i.dst, grid_ar_i.dst};

    // State register.
    // NOTE: the holding registers are reset too so the AW/AR payload driven
    // while idle is a defined '0 rather than X after power-up.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_q      <= '0;
            ar_q      <= '0;
            wr_src_q  <= '0;
            rd_src_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_q      <= aw_d;
            ar_q      <= ar_d;
            wr_src_q  <= wr_src_d;
            rd_src_q  <= rd_src_d;
        end
    end

    // Write next-state logic.
    always_comb begin
        // NOTE: every output of this block gets a hold default first; a path
        // that skips an assignment would otherwise infer a latch.
        w_state_d = w_state_q;
        aw_d      = aw_q;
        wr_src_d  = wr_src_q;
        unique case (w_state_q)
            W_IDLE: if (aw_hs) begin
                aw_d      = grid_aw_i.payload;
                wr_src_d  = grid_aw_i.src;
                w_state_d = W_AW;
            end
            W_AW:   if (aw_acc)    w_state_d = W_DATA;
            W_DATA: if (w_last_hs) w_state_d = W_RESP;
            W_RESP: if (b_hs)      w_state_d = W_IDLE;
            default:               w_state_d = W_IDLE;
        endcase
    end

    // Read next-state logic.
    always_comb begin
        r_state_d = r_state_q;
        ar_d      = ar_q;
        rd_src_d  = rd_src_q;
        unique case (r_state_q)
            R_IDLE: if (ar_hs) begin
                ar_d      = grid_ar_i.payload;
                rd_src_d  = grid_ar_i.src;
                r_state_d = R_AR;
            end
            R_AR:   if (ar_acc)    r_state_d = R_DATA;
            R_DATA: if (r_last_hs) r_state_d = R_IDLE;
            default:               r_state_d = R_IDLE;
        endcase
    end

    // Output logic for both FSMs. Payloads are always driven; only the
    // valid/ready strobes depend on state, so they alone need gating.
    always_comb begin
        req_o           = '0;
        req_o.aw        = aw_q;
        req_o.ar        = ar_q;
        req_o.w         = grid_w_i.payload;
        grid_aw_ready_o = 1'b0;
        grid_w_ready_o  = 1'b0;
        grid_ar_ready_o = 1'b0;
        grid_b_valid_o  = 1'b0;
        grid_r_valid_o  = 1'b0;
        grid_b_o.src     = NI_ID;
        grid_b_o.dst     = wr_src_q;
        grid_b_o.payload = resp_i.b;
        grid_r_o.src     = NI_ID;
        grid_r_o.dst     = rd_src_q;
        grid_r_o.payload = resp_i.r;

        unique case (w_state_q)
            W_IDLE: grid_aw_ready_o = 1'b1;
            W_AW:   req_o.aw_valid  = 1'b1;
            W_DATA: begin
                req_o.w_valid  = grid_w_valid_i;
                grid_w_ready_o = resp_i.w_ready;
            end
            W_RESP: begin
                grid_b_valid_o = resp_i.b_valid;
                req_o.b_ready  = grid_b_ready_i;
            end
            default: ;
        endcase

        unique case (r_state_q)
            R_IDLE: grid_ar_ready_o = 1'b1;
            R_AR:   req_o.ar_valid  = 1'b1;
            R_DATA: begin
                grid_r_valid_o = resp_i.r_valid;
                req_o.r_ready  = grid_r_ready_i;
            end
            default: ;
        endcase
    end

`ifdef SIMULATION
    // Misrouted flits are still consumed; this only flags them.
    a_aw_dst: assert property (@(posedge clk_i) disable iff (!arst_ni)
        aw_hs |-> grid_aw_i.dst == NI_ID) else $error("misrouted AW flit");
    a_w_dst: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (grid_w_valid_i & grid_w_ready_o) |-> grid_w_i.dst == NI_ID) else $error("misrouted W flit");
    a_ar_dst: assert property (@(posedge clk_i) disable iff (!arst_ni)
        ar_hs |-> grid_ar_i.dst == NI_ID) else $error("misrouted AR flit");
`endif

endmodule

// File: doc/axi_grid_mni.md
# axi_grid_mni

Master-side network interface for the AXI grid: takes AW/W/AR packets arriving from the grid and drives them as an AXI manager onto one local subordinate. It returns B and R beats to the originating slave-side NI, addressed by the source ID captured from the request. It pairs with `axi_grid_sni` at the far end of every grid transaction. It supports one outstanding write and one outstanding read, and the two paths run independently and concurrently.

## Interface
- `req_t`, `axi_default_param_pkg::mni_req_t`: AXI manager request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- `resp_t`, `axi_default_param_pkg::mni_resp_t`: AXI response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).
- `grid_id_t`, `axi_default_param_pkg::grid_id_t`: grid node ID.
- `grid_aw_chan_t` / `grid_w_chan_t` / `grid_b_chan_t` / `grid_ar_chan_t` / `grid_r_chan_t`, `axi_default_param_pkg` types: grid flits.
  - Each flit has fields `src`, `dst` (grid_id_t) and `payload` (the AXI channel).
- `NI_ID`, `'0`: this node's grid ID.
- `clk_i`  in  1  clock.
- `arst_ni`  in  1  asynchronous active-low reset.
- `req_o`  out  req_t  AXI request to the subordinate.
- `resp_i`  in  resp_t  AXI response from the subordinate.
- `grid_aw_i` / `grid_aw_valid_i` / `grid_aw_ready_o`: in / in / out; widths grid_aw_chan_t / 1 / 1; incoming write address.
- `grid_w_i` / `grid_w_valid_i` / `grid_w_ready_o`: in / in / out; widths grid_w_chan_t / 1 / 1; incoming write data.
- `grid_ar_i` / `grid_ar_valid_i` / `grid_ar_ready_o`: in / in / out; widths grid_ar_chan_t / 1 / 1; incoming read address.
- `grid_b_o` / `grid_b_valid_o` / `grid_b_ready_i`: out / out / in; widths grid_b_chan_t / 1 / 1; outgoing write response.
- `grid_r_o` / `grid_r_valid_o` / `grid_r_ready_i`: out / out / in; widths grid_r_chan_t / 1 / 1; outgoing read data.

## Operation
- Write FSM states: W_IDLE, W_AW, W_DATA, W_RESP.
  - W_IDLE: `grid_aw_ready_o`=1. On an AW handshake, register `payload` into the AW holding register and `src` into `wr_src`, then go to W_AW.
  - W_AW: `req_o.aw_valid`=1 with the held payload. On `resp_i.aw_ready`, go to W_DATA.
  - W_DATA: W path is combinational pass-through.
    - `req_o.w_valid` = `grid_w_valid_i`, `req_o.w` = `grid_w_i.payload`, `grid_w_ready_o` = `resp_i.w_ready`.
    - A handshake with `w.last`=1 moves the FSM to W_RESP.
  - W_RESP: B path is combinational pass-through.
    - `grid_b_valid_o` = `resp_i.b_valid`, `req_o.b_ready` = `grid_b_ready_i`.
    - `grid_b_o.payload` = `resp_i.b`, `.dst` = `wr_src`, `.src` = `NI_ID`.
    - On a B handshake, go to W_IDLE.
- Read FSM states: R_IDLE, R_AR, R_DATA.
  - R_IDLE: `grid_ar_ready_o`=1. On an AR handshake, latch payload and `rd_src`, then go to R_AR.
  - R_AR: `req_o.ar_valid`=1. On `resp_i.ar_ready`, go to R_DATA.
  - R_DATA: R path is pass-through, with `.dst` = `rd_src` and `.src` = `NI_ID`. A handshake with `r.last`=1 returns the FSM to R_IDLE.
- Outside the listed states, every valid and ready this block drives is 0. W flits arriving before W_DATA stall.
- Flits with `dst` != `NI_ID` are consumed as normal. Under `SIMULATION`, an assertion flags them.
- AXI IDs, lengths and data pass through unmodified. This block does no ID remapping or burst splitting.

## Timing
- Reset values:
  - All `*_valid` outputs 0; `req_o.b_ready` and `req_o.r_ready` 0.
  - `grid_aw_ready_o`=1 and `grid_ar_ready_o`=1 (FSMs in IDLE).
  - Holding registers and `wr_src` / `rd_src` are '0.
- AW/AR latency: grid handshake in cycle N gives `req_o.*_valid`=1 in cycle N+1. Valid holds with a stable payload until ready.
- W, B and R paths: zero added latency (combinational).
- Minimum write: AW accepted at N, AXI AW at N+1, first W at N+2 at the earliest.
- `grid_aw_ready_o` returns to 1 the cycle after the B handshake. The AR/R path behaves the same way.
- Write and read FSMs are independent. Simultaneous grid AW and AR valids are both accepted in the same cycle.
- AW handshake and `aw_ready` in the same cycle are impossible: aw_valid is registered.
- Reset mid-transaction: both FSMs go to IDLE immediately (asynchronously). The in-flight transaction is dropped and no B/R is produced.

## Test plan
- Single write: AW (src=3, len=0) then W (last=1), subordinate sends B=OKAY. Required: `req_o.aw_valid` one cycle after the grid AW handshake, and `grid_b_o` with dst=3, src=`NI_ID`, resp OKAY.
- Read burst: AR (src=5, len=3), subordinate returns 4 beats with last on beat 4. Required: 4 grid R beats with dst=5, data in order, and `grid_ar_ready_o`=1 the cycle after the last beat.
- Backpressure: `aw_ready` low for 4 cycles, `w_ready` toggling, `grid_b_ready_i` low for 3 cycles. Required: aw_valid and payload stable throughout, no lost or duplicated beats, and no second AW accepted before the B handshake.
- Concurrency: grid AW (src=1) and AR (src=2) valid in the same cycle. Required: both accepted that cycle, and B returns to 1 and R to 2 regardless of completion order.
- Early W: W flit presented 3 cycles before AW. Required: `grid_w_ready_o`=0 until W_DATA, then the beat is forwarded intact.
- Reset mid-burst: `arst_ni` low during beat 2 of a 4-beat read. Required: all valids 0 immediately, then normal operation on the next transaction after reset release.
